// File: rtl/text_marquee_pkg.sv
// Shared font constants for the text marquee: glyph geometry, character codes
// and the power-on message.
package text_marquee_pkg;

  localparam int unsigned FONT_W = 5;
  localparam int unsigned FONT_H = 7;

  localparam logic [5:0] CH_SPACE = 6'd0;
  localparam logic [5:0] CH_A = 6'd1;
  localparam logic [5:0] CH_B = 6'd2;
  localparam logic [5:0] CH_C = 6'd3;
  localparam logic [5:0] CH_D = 6'd4;
  localparam logic [5:0] CH_E = 6'd5;
  localparam logic [5:0] CH_F = 6'd6;
  localparam logic [5:0] CH_G = 6'd7;
  localparam logic [5:0] CH_H = 6'd8;
  localparam logic [5:0] CH_I = 6'd9;
  localparam logic [5:0] CH_J = 6'd10;
  localparam logic [5:0] CH_K = 6'd11;
  localparam logic [5:0] CH_L = 6'd12;
  localparam logic [5:0] CH_M = 6'd13;
  localparam logic [5:0] CH_N = 6'd14;
  localparam logic [5:0] CH_O = 6'd15;
  localparam logic [5:0] CH_P = 6'd16;
  localparam logic [5:0] CH_Q = 6'd17;
  localparam logic [5:0] CH_R = 6'd18;
  localparam logic [5:0] CH_S = 6'd19;
  localparam logic [5:0] CH_T = 6'd20;
  localparam logic [5:0] CH_U = 6'd21;
  localparam logic [5:0] CH_V = 6'd22;
  localparam logic [5:0] CH_W = 6'd23;
  localparam logic [5:0] CH_X = 6'd24;
  localparam logic [5:0] CH_Y = 6'd25;
  localparam logic [5:0] CH_Z = 6'd26;
  localparam logic [5:0] CH_0 = 6'd27;
  localparam logic [5:0] CH_1 = 6'd28;
  localparam logic [5:0] CH_2 = 6'd29;
  localparam logic [5:0] CH_3 = 6'd30;
  localparam logic [5:0] CH_4 = 6'd31;
  localparam logic [5:0] CH_5 = 6'd32;
  localparam logic [5:0] CH_6 = 6'd33;
  localparam logic [5:0] CH_7 = 6'd34;
  localparam logic [5:0] CH_8 = 6'd35;
  localparam logic [5:0] CH_9 = 6'd36;

  localparam int unsigned DEFAULT_MSG_LEN = 8;

  // "TT08 IHP", slot 0 in the least significant six bits.
  localparam logic [47:0] DEFAULT_MSG = {CH_P, CH_H, CH_I, CH_SPACE, CH_8, CH_0, CH_T, CH_T};

  // Reset code for a slot; slots beyond the default message start blank.
  function automatic logic [5:0] default_char(int slot);
    logic [47:0] shifted;
    shifted = DEFAULT_MSG >> (6 * slot);
    if (slot < int'(DEFAULT_MSG_LEN)) begin
      return shifted[5:0];
    end
    return CH_SPACE;
  endfunction

endpackage

// File: rtl/font_rom_5x7.sv
// Combinational 5x7 glyph ROM; bit 4 of the returned row is the leftmost column.
// Codes outside the defined set, and row 7, read as blank.
module font_rom_5x7
  import text_marquee_pkg::*;
(
  input  logic [5:0] code,
  input  logic [2:0] row,
  output logic [4:0] bits
);

  // Seven 5-bit rows, top row in the most significant bits.
  logic [34:0] glyph;

  always_comb begin
    glyph = '0;
    case (code)
      CH_A: glyph = 35'b01110_10001_10001_11111_10001_10001_10001;
      CH_B: glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
      CH_C: glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
      CH_D: glyph = 35'b11100_10010_10001_10001_10001_10010_11100;
      CH_E: glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
      CH_F: glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
      CH_G: glyph = 35'b01110_10001_10000_10111_10001_10001_01111;
      CH_H: glyph = 35'b10001_10001_10001_11111_10001_10001_10001;
      CH_I: glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
      CH_J: glyph = 35'b00111_00010_00010_00010_00010_10010_01100;
      CH_K: glyph = 35'b10001_10010_10100_11000_10100_10010_10001;
      CH_L: glyph = 35'b10000_10000_10000_10000_10000_10000_11111;
      CH_M: glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
      CH_N: glyph = 35'b10001_10001_11001_10101_10011_10001_10001;
      CH_O: glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
      CH_P: glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
      CH_Q: glyph = 35'b01110_10001_10001_10001_10101_10010_01101;
      CH_R: glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
      CH_S: glyph = 35'b01111_10000_10000_01110_00001_00001_11110;
      CH_T: glyph = 35'b11111_00100_00100_00100_00100_00100_00100;
      CH_U: glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
      CH_V: glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
      CH_W: glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
      CH_X: glyph = 35'b10001_10001_01010_00100_01010_10001_10001;
      CH_Y: glyph = 35'b10001_10001_01010_00100_00100_00100_00100;
      CH_Z: glyph = 35'b11111_00001_00010_00100_01000_10000_11111;
      CH_0: glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
      CH_1: glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
      CH_2: glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
      CH_3: glyph = 35'b11111_00010_00100_00010_00001_10001_01110;
      CH_4: glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
      CH_5: glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
      CH_6: glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
      CH_7: glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
      CH_8: glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
      CH_9: glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
      default: glyph = '0;
    endcase
  end

  always_comb begin
    bits = '0;
    case (row)
      3'd0: bits = glyph[34:30];
      3'd1: bits = glyph[29:25];
      3'd2: bits = glyph[24:20];
      3'd3: bits = glyph[19:15];
      3'd4: bits = glyph[14:10];
      3'd5: bits = glyph[9:5];
      3'd6: bits = glyph[4:0];
      default: bits = '0;
    endcase
  end

endmodule

// File: rtl/text_marquee.sv
// Scrolling, blinking text overlay: renders a writable message from the 5x7
// font inside a cell window and registers the resulting pixel.
module text_marquee
  import text_marquee_pkg::*;
#(
  parameter int unsigned SCALE_LOG2 = 3,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned CHAR_PITCH = 6,
  parameter int unsigned WIN_X      = 8,
  parameter int unsigned WIN_Y      = 25,
  parameter int unsigned WIN_W      = 48,
  parameter int unsigned SCROLL_DIV = 2,
  parameter int unsigned BLINK_DIV  = 30
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [8:0]                 x,
  input  logic [8:0]                 y,
  input  logic                       frame_tick,
  input  logic                       enable,
  input  logic                       scroll_en,
  input  logic                       blink_en,
  input  logic                       char_wr,
  input  logic [$clog2(MSG_LEN)-1:0] char_addr,
  input  logic [5:0]                 char_code,
  output logic                       overlay_active
);

  localparam int unsigned AW    = $clog2(MSG_LEN);
  localparam int unsigned TOTAL = MSG_LEN * CHAR_PITCH;
  localparam int unsigned PW    = $clog2(TOTAL);
  localparam int unsigned SCW   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int unsigned BCW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [5:0]     msg_q [MSG_LEN];
  logic [5:0]     msg_d [MSG_LEN];
  logic [PW-1:0]  scroll_pos_q, scroll_pos_d;
  logic [SCW-1:0] scroll_cnt_q, scroll_cnt_d;
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_phase_q, blink_phase_d;

  int         wx, rw, vc, idx, col;
  logic       in_win;
  logic [5:0] glyph_code;
  logic [2:0] font_row;
  logic [4:0] font_bits;
  logic       col_bit;
  logic       pix;

  // Window-relative coordinates are signed so pixels left of/above the window
  // fall out naturally as negative.
  always_comb begin
    wx     = int'(x >> SCALE_LOG2) - int'(WIN_X);
    rw     = int'(y >> SCALE_LOG2) - int'(WIN_Y);
    in_win = (wx >= 0) && (wx < int'(WIN_W)) && (rw >= 0) && (rw < 8);
    vc     = wx + int'(scroll_pos_q);
    if (vc >= int'(TOTAL)) begin
      vc = vc - int'(TOTAL);
    end
    idx        = vc / int'(CHAR_PITCH);
    col        = vc % int'(CHAR_PITCH);
    glyph_code = CH_SPACE;
    if (in_win && (idx >= 0) && (idx < int'(MSG_LEN))) begin
      glyph_code = msg_q[AW'(idx)];
    end
    font_row = rw[2:0];
  end

  font_rom_5x7 u_font (
    .code (glyph_code),
    .row  (font_row),
    .bits (font_bits)
  );

  always_comb begin
    col_bit = 1'b0;
    if ((col >= 0) && (col < int'(FONT_W))) begin
      col_bit = font_bits[3'(int'(FONT_W) - 1 - col)];
    end
    pix = in_win && col_bit && (rw < int'(FONT_H)) && enable && !(blink_en && blink_phase_q);
  end

  always_comb begin
    scroll_pos_d  = scroll_pos_q;
    scroll_cnt_d  = scroll_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    msg_d         = msg_q;

    if (frame_tick && scroll_en) begin
      if (scroll_cnt_q == SCW'(SCROLL_DIV - 1)) begin
        scroll_cnt_d = '0;
        scroll_pos_d = (scroll_pos_q == PW'(TOTAL - 1)) ? '0 : scroll_pos_q + PW'(1);
      end else begin
        scroll_cnt_d = scroll_cnt_q + SCW'(1);
      end
    end

    // Blink timing free-runs so enabling blink does not restart the phase.
    if (frame_tick) begin
      if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end
    end

    if (char_wr && (int'(char_addr) < int'(MSG_LEN))) begin
      msg_d[char_addr] = char_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overlay_active <= 1'b0;
      scroll_pos_q   <= '0;
      scroll_cnt_q   <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      for (int i = 0; i < int'(MSG_LEN); i++) begin
        msg_q[i] <= default_char(i);
      end
    end else begin
      overlay_active <= pix;
      scroll_pos_q   <= scroll_pos_d;
      scroll_cnt_q   <= scroll_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      msg_q          <= msg_d;
    end
  end

endmodule

// File: tb/tb_text_marquee.sv
// Directed bench for text_marquee: default-parameter instance plus a short
// message / fast-blink instance sharing the same stimulus.
module tb_text_marquee;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] x, y;
  logic       frame_tick, enable, scroll_en, blink_en, char_wr;
  logic [2:0] char_addr;
  logic [5:0] char_code;
  logic       ov_a, ov_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  text_marquee dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .x              (x),
    .y              (y),
    .frame_tick     (frame_tick),
    .enable         (enable),
    .scroll_en      (scroll_en),
    .blink_en       (blink_en),
    .char_wr        (char_wr),
    .char_addr      (char_addr),
    .char_code      (char_code),
    .overlay_active (ov_a)
  );

  text_marquee #(
    .MSG_LEN   (6),
    .WIN_W     (36),
    .BLINK_DIV (2)
  ) dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .x              (x),
    .y              (y),
    .frame_tick     (frame_tick),
    .enable         (enable),
    .scroll_en      (scroll_en),
    .blink_en       (blink_en),
    .char_wr        (char_wr),
    .char_addr      (char_addr),
    .char_code      (char_code),
    .overlay_active (ov_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a pixel and let it pass through the output register.
  task automatic step_xy(input logic [8:0] px, input logic [8:0] py);
    x = px;
    y = py;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    x          = 9'd64;
    y          = 9'd200;
    frame_tick = 1'b0;
    enable     = 1'b1;
    scroll_en  = 1'b0;
    blink_en   = 1'b0;
    char_wr    = 1'b0;
    char_addr  = '0;
    char_code  = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("reset_out", ov_a, 0);
    rst_n = 1'b1;

    // Default message, scroll 0: slot0 'T' at cells 8..12, row 0 at y=200.
    step_xy(64, 200);  check_eq("t_row0_col0", ov_a, 1);
    step_xy(104, 200); check_eq("gap_col", ov_a, 0);
    step_xy(63, 200);  check_eq("left_of_win", ov_a, 0);
    step_xy(64, 199);  check_eq("above_win", ov_a, 0);
    step_xy(72, 208);  check_eq("t_row1_col1", ov_a, 0);
    step_xy(80, 208);  check_eq("t_row1_col2", ov_a, 1);
    step_xy(80, 248);  check_eq("t_row6_col2", ov_a, 1);
    step_xy(80, 256);  check_eq("row7_blank", ov_a, 0);
    step_xy(352, 200); check_eq("a_slot6_h", ov_a, 1);
    check_eq("b_beyond_winw", ov_b, 0);
    enable = 1'b0;
    step_xy(64, 200);  check_eq("enable_off", ov_a, 0);
    enable = 1'b1;

    // Scrolling, two ticks per step.
    scroll_en = 1'b1;
    tick(2);
    step_xy(72, 208);  check_eq("pos1_wx1", ov_a, 1);
    step_xy(80, 208);  check_eq("pos1_wx2", ov_a, 0);
    tick(90);
    step_xy(64, 208);  check_eq("pos46_p_col4", ov_a, 1);
    step_xy(72, 208);  check_eq("pos46_gap", ov_a, 0);
    step_xy(96, 208);  check_eq("pos46_wrap_t", ov_a, 1);
    step_xy(88, 208);  check_eq("pos46_wrap_t1", ov_a, 0);
    tick(4);
    step_xy(80, 208);  check_eq("pos0_again_wx2", ov_a, 1);
    step_xy(72, 208);  check_eq("pos0_again_wx1", ov_a, 0);

    // Hold with a half-finished divider, then resume.
    tick(1);
    scroll_en = 1'b0;
    tick(10);
    step_xy(80, 208);  check_eq("hold_wx2", ov_a, 1);
    step_xy(72, 208);  check_eq("hold_wx1", ov_a, 0);
    scroll_en = 1'b1;
    tick(1);
    step_xy(72, 208);  check_eq("resume_wx1", ov_a, 1);

    // Write slot 0 to space: same-cycle read still sees 'T'.
    scroll_en = 1'b0;
    do_reset();
    x = 9'd64;
    y = 9'd200;
    char_wr   = 1'b1;
    char_addr = 3'd0;
    char_code = 6'd0;
    @(posedge clk);
    #1;
    char_wr = 1'b0;
    check_eq("wr_old_visible", ov_a, 1);
    @(posedge clk);
    #1;
    check_eq("wr_new_visible", ov_a, 0);

    // Reset mid-scroll at position 17.
    scroll_en = 1'b1;
    tick(34);
    step_xy(72, 208);  check_eq("pos17_8_col0", ov_a, 1);
    step_xy(64, 208);  check_eq("pos17_gap", ov_a, 0);
    x = 9'd72;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midreset_out", ov_a, 0);
    rst_n = 1'b1;
    scroll_en = 1'b0;
    step_xy(72, 208);  check_eq("post_reset_pos0", ov_a, 0);
    step_xy(64, 200);  check_eq("post_reset_msg", ov_a, 1);

    // Out-of-range write on the six-slot instance; slot 6 is real on dut_a.
    char_wr   = 1'b1;
    char_addr = 3'd6;
    char_code = 6'd0;
    @(posedge clk);
    #1;
    char_wr = 1'b0;
    step_xy(64, 200);  check_eq("b_slot0_kept", ov_b, 1);
    step_xy(312, 200); check_eq("b_slot5_kept", ov_b, 1);
    step_xy(352, 200); check_eq("a_slot6_written", ov_a, 0);

    // Blink: dut_b toggles every 2 ticks, dut_a every 30.
    do_reset();
    blink_en = 1'b1;
    step_xy(64, 200);  check_eq("b_blink_ph0", ov_b, 1);
    tick(2);
    step_xy(64, 200);  check_eq("b_blink_ph1", ov_b, 0);
    check_eq("a_blink_slow", ov_a, 1);
    tick(2);
    step_xy(64, 200);  check_eq("b_blink_back", ov_b, 1);
    tick(2);
    step_xy(64, 200);  check_eq("b_blink_again", ov_b, 0);
    blink_en = 1'b0;
    step_xy(64, 200);  check_eq("b_blink_off", ov_b, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
